// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Burst counter must hold 0..MAX_BURST-1 with one bit of headroom.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Requester and downstream signals of the shared 2:1 mux arbiter.
interface mux2_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    // Handshakes: a requester holds req_x and data_x stable until gnt_x, which
    // is the combinational accept of that word in the same cycle. Downstream,
    // a word moves whenever out_valid and out_ready are both high on a rising edge.
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             gnt_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             gnt_b;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport slave (
        input  req_a, data_a, req_b, data_b, out_ready,
        output gnt_a, gnt_b, sel, out_valid, out_data
    );

    modport master (
        output req_a, data_a, req_b, data_b, out_ready,
        input  gnt_a, gnt_b, sel, out_valid, out_data
    );
endinterface

// File: rtl/mux2_arb_datapath.sv
// WIDTH-wide 2:1 mux steered by the registered select, feeding the output word register.
module mux2_arb_datapath
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic             load,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = (sel == SEL_B) ? data_b : data_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign out_data = data_q;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between requesters A and B,
// with bursts capped at MAX_BURST words and a registered valid/ready output.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    mux2_rr_arbiter_if.slave                    bus,
    output state_t                              dbg_state,
    output logic [cnt_width(MAX_BURST)-1:0]     dbg_cnt
);

    localparam int CW = cnt_width(MAX_BURST);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic          valid_q, valid_d;

    logic can_load;
    logic xfer;
    logic gnt_a, gnt_b;

    assign can_load = !valid_q || bus.out_ready;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        xfer    = 1'b0;

        // A word leaving with nothing replacing it empties the register.
        if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.req_a && bus.req_b) begin
                    state_d = (last_q == SEL_B) ? GRANT_A : GRANT_B;
                end else if (bus.req_a) begin
                    state_d = GRANT_A;
                end else if (bus.req_b) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!bus.req_a) begin
                    last_d  = SEL_A;
                    cnt_d   = '0;
                    state_d = bus.req_b ? GRANT_B : IDLE;
                end else if (can_load && !reset) begin
                    xfer    = 1'b1;
                    gnt_a   = 1'b1;
                    valid_d = 1'b1;
                    if (cnt_q == CW'(MAX_BURST - 1)) begin
                        last_d = SEL_A;
                        cnt_d  = '0;
                        if (bus.req_b) state_d = GRANT_B;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            GRANT_B: begin
                if (!bus.req_b) begin
                    last_d  = SEL_B;
                    cnt_d   = '0;
                    state_d = bus.req_a ? GRANT_A : IDLE;
                end else if (can_load && !reset) begin
                    xfer    = 1'b1;
                    gnt_b   = 1'b1;
                    valid_d = 1'b1;
                    if (cnt_q == CW'(MAX_BURST - 1)) begin
                        last_d = SEL_B;
                        cnt_d  = '0;
                        if (bus.req_a) state_d = GRANT_A;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        sel_d = (state_d == GRANT_B) ? SEL_B : SEL_A;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= SEL_B;
            cnt_q   <= '0;
            sel_q   <= SEL_A;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    mux2_arb_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel_q),
        .load     (xfer),
        .data_a   (bus.data_a),
        .data_b   (bus.data_b),
        .out_data (bus.out_data)
    );

    assign bus.gnt_a     = gnt_a;
    assign bus.gnt_b     = gnt_b;
    assign bus.sel       = sel_q;
    assign bus.out_valid = valid_q;
    assign dbg_state     = state_q;
    assign dbg_cnt       = cnt_q;

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit 2:1 mux datapath between two requesters (A, B).
- Drives the mux select, accepts one word per cycle from the granted requester, and presents it on a registered valid/ready output port.
- Bounds each grant to MAX_BURST transfers so neither requester can starve the other.
- Sits between two producer blocks and a single shared downstream consumer.

Parameters:
WIDTH, 8, data width of each requester and of the output
MAX_BURST, 4, max consecutive transfers per grant before yielding (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req_a  input  1  requester A has a word on data_a
data_a  input  WIDTH  requester A data
gnt_a  output  1  A's word accepted this cycle (combinational)
req_b  input  1  requester B has a word on data_b
data_b  input  WIDTH  requester B data
gnt_b  output  1  B's word accepted this cycle (combinational)
sel  output  1  mux select: 0=A, 1=B (registered)
out_valid  output  1  out_data holds a valid word
out_data  output  WIDTH  registered output word
out_ready  input  1  downstream accepts out_data this cycle

Behaviour:
- Reset: state=IDLE, last_served=B (so A wins the first tie), cnt=0, sel=0, out_valid=0, out_data=0. gnt_a and gnt_b are 0 while reset is high. A reset mid-burst discards the output register contents.
- can_load = !out_valid | out_ready.
- IDLE: no transfer. If only one req is high, go to that requester's GRANT state. If both are high, grant the requester other than last_served. One cycle of arbitration latency.
- GRANT_X (X is A or B): xfer = req_x & can_load; gnt_x = xfer; the other gnt is 0.
  - On xfer: out_data <= data_x, out_valid <= 1, cnt++.
  - No xfer because of backpressure (req_x=1, can_load=0): hold state, cnt and out_data.
  - req_x=0: last_served <= X, cnt <= 0. Go to the other GRANT if the other req is high, else IDLE.
  - xfer with cnt==MAX_BURST-1: last_served <= X, cnt <= 0. Go to the other GRANT if the other req is high, else stay in GRANT_X (new burst).
- sel = 1 only in GRANT_B, 0 otherwise. It updates on the same edge as the state.
- out_valid is cleared when out_ready=1 and there is no xfer. Simultaneous accept and reload gives back-to-back throughput of one word per cycle.
- Requester contract: hold req_x high and data_x stable until gnt_x. Deasserting req without a grant withdraws the request.
- cnt width is clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1.

Decomposition:
- Package mux2_arb_pkg holds:
  - the state enum (IDLE, GRANT_A, GRANT_B)
  - constants SEL_A=0, SEL_B=1
  - a function computing cnt width from MAX_BURST
- Sub-module mux2_arb_datapath: a WIDTH-wide 2:1 mux driven by sel, feeding the out_data register. The FSM, counter and handshake logic stay in the top.

Test Plan:
1. Hold reset 3 cycles with req_a=req_b=1 -> gnt_a=gnt_b=0, out_valid=0, out_data=0, sel=0. After release: GRANT_A one cycle later, A served first.
2. Only req_a=1, data_a incrementing 0x10.., out_ready=1 -> gnt_a high from cycle 2. out_data=0x10,0x11,0x12... one per cycle. sel=0. Grant never yields to idle B.
3. Both requesting continuously, out_ready=1, MAX_BURST=4 -> output order A×4, B×4, A×4. sel toggles every 4 transfers. No bubbles at the switch.
4. Mid-burst (after 2 A words, out_valid=1 with 0x11), drive out_ready=0 for 5 cycles -> gnt_a=0, out_data stays 0x11, cnt stays 2. After release, 2 more A words complete the burst, then B.
5. A drops req_a after 2 transfers while req_b=1 -> next cycle sel=1, gnt_b=1. B gets a full 4-word burst (cnt restarted).
6. Assert reset during a B burst with out_valid=1 -> next cycle out_valid=0, gnt_b=0, sel=0, state IDLE. With both requesting afterwards, A is granted first.
